// File: rtl/arth_pkg.sv
// Shared definitions for the arithmetic datapath sequencer: opcodes, state encoding
// and default widths.
package arth_pkg;

    localparam int DEFAULT_OP_W  = 4;
    localparam int DEFAULT_RES_W = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic logic op_supported(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/arth_sequencer.sv
// Sequences one command at a time through the shared arithmetic datapath and returns its answer.
// Optional macro ARTH_SEQ_OPCOUNT_EN adds a saturating count of successful results on op_count.
module arth_sequencer
    import arth_pkg::*;
#(
    parameter int OP_W       = DEFAULT_OP_W,
    parameter int RES_W      = DEFAULT_RES_W,
    parameter int DP_LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic [OP_W-1:0]  cmd_v1,
    input  logic [OP_W-1:0]  cmd_v2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             res_err,
    output logic [OP_W-1:0]  dp_v1,
    output logic [OP_W-1:0]  dp_v2,
    output logic [1:0]       dp_opcode,
    output logic             dp_newop,
    input  logic [RES_W-1:0] dp_ans,
    output logic [1:0]       state_dbg
`ifdef ARTH_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    // Both ports transfer on a clock edge where valid && ready are high; valid,
    // payload and ready are driven from flops and never depend on the other side.
    localparam logic [3:0] LAT = 4'(DP_LATENCY);

    seq_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             res_err_q, res_err_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]  dp_v1_q, dp_v1_d;
    logic [OP_W-1:0]  dp_v2_q, dp_v2_d;
    logic [1:0]       dp_opcode_q, dp_opcode_d;
    logic             dp_newop_q, dp_newop_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        res_data_d  = res_data_q;
        dp_v1_d     = dp_v1_q;
        dp_v2_d     = dp_v2_q;
        dp_opcode_d = dp_opcode_q;
        dp_newop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (op_supported(cmd_opcode)) begin
                        dp_v1_d     = cmd_v1;
                        dp_v2_d     = cmd_v2;
                        dp_opcode_d = cmd_opcode;
                        dp_newop_d  = 1'b1;
                        state_d     = ST_ISSUE;
                    end else begin
                        // Rejected opcodes never reach the datapath registers.
                        res_err_d   = 1'b1;
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    res_data_d  = dp_ans;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            dp_v1_q     <= '0;
            dp_v2_q     <= '0;
            dp_opcode_q <= '0;
            dp_newop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            res_data_q  <= res_data_d;
            dp_v1_q     <= dp_v1_d;
            dp_v2_q     <= dp_v2_d;
            dp_opcode_q <= dp_opcode_d;
            dp_newop_q  <= dp_newop_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign res_data  = res_data_q;
    assign dp_v1     = dp_v1_q;
    assign dp_v2     = dp_v2_q;
    assign dp_opcode = dp_opcode_q;
    assign dp_newop  = dp_newop_q;
    assign state_dbg = state_q;

`ifdef ARTH_SEQ_OPCOUNT_EN
    logic [15:0] op_count_q, op_count_d;

    // Only successful results count, and the count sticks at all-ones.
    always_comb begin
        op_count_d = op_count_q;
        if (res_valid_q && res_ready && !res_err_q && (op_count_q != 16'hFFFF))
            op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) op_count_q <= '0;
        else       op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule
